// File: rtl/sram_bank_sequencer_if.sv
// Request/response bundle between an upstream master and the SRAM bank sequencer.
interface sram_bank_sequencer_if #(
  parameter int AW = 5,
  parameter int DW = 16
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr_a;
  logic [AW-1:0] req_addr_b;
  logic [DW-1:0] req_wdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          busy;

  modport master (
    output req_valid, req_wr, req_addr_a, req_addr_b, req_wdata,
    input  req_ready, rd_valid, rd_data_a, rd_data_b, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr_a, req_addr_b, req_wdata,
    output req_ready, rd_valid, rd_data_a, rd_data_b, busy
  );
endinterface

// File: rtl/sram_bank_sequencer.sv
// Sequences one read/write per Bennett cycle onto the 2-port SRAM bank phase edges.
// Optional write-to-read forwarding is enabled by defining WR_FORWARD_EN.
module sram_bank_sequencer #(
  parameter int PHASES    = 10,
  parameter int AW        = 5,
  parameter int DW        = 16,
  parameter int PH_ADDR   = 2,
  parameter int PH_DATA   = 4,
  parameter int PH_RD_ON  = 6,
  parameter int PH_RD_OFF = 8,
  parameter int PH_WR_ON  = 8,
  parameter int PH_WR_OFF = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PHASES-1:0]     clkpos,
  input  logic                  Mclk,
  sram_bank_sequencer_if.slave  req,
  input  logic [DW-1:0]         outA,
  input  logic [DW-1:0]         outB,
  output logic [AW-1:0]         Addr_A,
  output logic [AW-1:0]         Addr_B,
  output logic [DW-1:0]         in,
  output logic                  ReadEn,
  output logic                  WriteEn,
  output logic                  RegWrtBar,
  output logic                  srclkneg,
  output logic                  srclkpos
);

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, W_EN, EN_ON} state_t;

  localparam logic [PHASES-1:0] ONE = 1;

  state_t            state;
  logic [PHASES-1:0] clkpos_q;
  logic [PHASES-1:0] rise;
  logic              lat_wr;
  logic [AW-1:0]     lat_a;
  logic [AW-1:0]     lat_b;
  logic [DW-1:0]     lat_wd;
  logic              rd_valid_q;
  logic [DW-1:0]     rd_data_a_q;
  logic [DW-1:0]     rd_data_b_q;
  logic              busy_q;
  logic [DW-1:0]     cap_a;
  logic [DW-1:0]     cap_b;
  logic              wr_done;

  // Every phase bit passes through the mask so the whole edge vector is consumed.
  function automatic logic rose(input logic [PHASES-1:0] r, input int ph);
    return |(r & (ONE << ph));
  endfunction

  assign rise    = clkpos & ~clkpos_q;
  assign wr_done = (state == EN_ON) && lat_wr && rose(rise, PH_WR_OFF);

  assign RegWrtBar = ~clkpos[6];
  assign srclkneg  = ~Mclk & clkpos[6];
  assign srclkpos  = ~srclkneg;

  assign req.req_ready = (state == IDLE);
  assign req.rd_valid  = rd_valid_q;
  assign req.rd_data_a = rd_data_a_q;
  assign req.rd_data_b = rd_data_b_q;
  assign req.busy      = busy_q;

`ifdef WR_FORWARD_EN
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_data;
  logic          last_wr_vld;

  // Snapshot of the most recent completed write, taken as WriteEn falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_wr_addr <= '0;
      last_wr_data <= '0;
      last_wr_vld  <= 1'b0;
    end else if (wr_done) begin
      last_wr_addr <= Addr_A;
      last_wr_data <= in;
      last_wr_vld  <= 1'b1;
    end
  end

  assign cap_a = (last_wr_vld && (Addr_A == last_wr_addr)) ? last_wr_data : outA;
  assign cap_b = (last_wr_vld && (Addr_B == last_wr_addr)) ? last_wr_data : outB;
`else
  assign cap_a = outA;
  assign cap_b = outB;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clkpos_q    <= '0;
      lat_wr      <= 1'b0;
      lat_a       <= '0;
      lat_b       <= '0;
      lat_wd      <= '0;
      Addr_A      <= '0;
      Addr_B      <= '0;
      in          <= '0;
      ReadEn      <= 1'b0;
      WriteEn     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      clkpos_q   <= clkpos;
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            lat_wr <= req.req_wr;
            lat_a  <= req.req_addr_a;
            lat_b  <= req.req_addr_b;
            lat_wd <= req.req_wdata;
            busy_q <= 1'b1;
            state  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (rose(rise, PH_ADDR)) begin
            Addr_A <= lat_a;
            Addr_B <= lat_b;
            state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (!lat_wr) begin
            state <= W_EN;
          end else if (rose(rise, PH_DATA)) begin
            in    <= lat_wd;
            state <= W_EN;
          end
        end
        W_EN: begin
          if (!lat_wr && rose(rise, PH_RD_ON)) begin
            ReadEn <= 1'b1;
            state  <= EN_ON;
          end else if (lat_wr && rose(rise, PH_WR_ON)) begin
            WriteEn <= 1'b1;
            state   <= EN_ON;
          end
        end
        EN_ON: begin
          if (!lat_wr && rose(rise, PH_RD_OFF)) begin
            ReadEn      <= 1'b0;
            rd_data_a_q <= cap_a;
            rd_data_b_q <= cap_b;
            rd_valid_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end else if (wr_done) begin
            WriteEn <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Directed bench for sram_bank_sequencer with a one-hot Bennett phase generator.
module tb_sram_bank_sequencer;
  localparam int PHASES = 10;
  localparam int AW     = 5;
  localparam int DW     = 16;
  localparam int PH_LEN = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PHASES-1:0] clkpos;
  logic Mclk;
  logic [DW-1:0] outA, outB;
  logic [AW-1:0] Addr_A, Addr_B;
  logic [DW-1:0] in_d;
  logic ReadEn, WriteEn, RegWrtBar, srclkneg, srclkpos;

  int n_vec = 0;
  int n_fail = 0;

  int ph, cnt, bcyc;

  int obs_ph_addr, obs_n_addr, obs_ph_in;
  int obs_we_on, obs_we_off, obs_re_on, obs_re_off;
  int obs_we_cyc, obs_re_cyc, obs_rdv;
  logic [DW-1:0] obs_rd_a, obs_rd_b;
  bit obs_both, obs_ready_early, obs_timeout;

  sram_bank_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  sram_bank_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .clkpos   (clkpos),
    .Mclk     (Mclk),
    .req      (bus.slave),
    .outA     (outA),
    .outB     (outB),
    .Addr_A   (Addr_A),
    .Addr_B   (Addr_B),
    .in       (in_d),
    .ReadEn   (ReadEn),
    .WriteEn  (WriteEn),
    .RegWrtBar(RegWrtBar),
    .srclkneg (srclkneg),
    .srclkpos (srclkpos)
  );

  always #5 clk = ~clk;

  // Bennett phases: one-hot, each phase PH_LEN clocks, changed 1ns after posedge.
  initial begin
    ph = 0; cnt = 0; bcyc = 0;
    clkpos = PHASES'(1); Mclk = 1'b1;
    forever begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == PH_LEN) begin
        cnt = 0;
        if (ph == PHASES-1) begin ph = 0; bcyc++; end
        else ph++;
      end
      clkpos = PHASES'(1) << ph;
      Mclk = (ph < 5);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] wd, input int start_ph);
    int guard;
    bit done, seen_busy;
    logic pwe, pre;
    obs_ph_addr = -1; obs_n_addr = -1; obs_ph_in = -1;
    obs_we_on = -1; obs_we_off = -1; obs_re_on = -1; obs_re_off = -1;
    obs_we_cyc = 0; obs_re_cyc = 0; obs_rdv = 0;
    obs_rd_a = 'x; obs_rd_b = 'x;
    obs_both = 0; obs_ready_early = 0; obs_timeout = 0;
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (!(ph == start_ph && cnt == 0 && bus.req_ready) && guard < 200);
    if (guard >= 200) begin obs_timeout = 1; return; end
    bus.req_valid = 1'b1; bus.req_wr = wr;
    bus.req_addr_a = a; bus.req_addr_b = b; bus.req_wdata = wd;
    pwe = WriteEn; pre = ReadEn;
    done = 0; seen_busy = 0;
    for (int i = 1; i <= 300 && !done; i++) begin
      @(negedge clk);
      if (i == 1) bus.req_valid = 1'b0;
      if (obs_ph_addr < 0 && Addr_A == a && Addr_B == b) begin obs_ph_addr = ph; obs_n_addr = i; end
      if (wr && obs_ph_in < 0 && in_d == wd) obs_ph_in = ph;
      if (WriteEn && !pwe) obs_we_on = ph;
      if (!WriteEn && pwe) obs_we_off = ph;
      if (ReadEn && !pre) obs_re_on = ph;
      if (!ReadEn && pre) obs_re_off = ph;
      if (WriteEn) obs_we_cyc++;
      if (ReadEn) obs_re_cyc++;
      if (WriteEn && ReadEn) obs_both = 1;
      if (bus.rd_valid) begin obs_rdv++; obs_rd_a = bus.rd_data_a; obs_rd_b = bus.rd_data_b; end
      if (bus.busy) seen_busy = 1;
      done = seen_busy && !bus.busy;
      if (bus.req_ready && !done) obs_ready_early = 1;
      pwe = WriteEn; pre = ReadEn;
    end
    if (!done) obs_timeout = 1;
    @(negedge clk);
    if (bus.rd_valid) obs_rdv++;
  endtask

  task automatic test_reset();
    int guard;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0;
    bus.req_addr_a = '0; bus.req_addr_b = '0; bus.req_wdata = '0;
    outA = '0; outB = '0;
    reset = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!(ph == 6 && cnt == 1) && guard < 100);
    n_vec++; if (WriteEn !== 1'b0 || ReadEn !== 1'b0) begin n_fail++; $display("FAIL rst_enables got we=%b re=%b want 0/0", WriteEn, ReadEn); end
    n_vec++; if (Addr_A !== 5'd0 || Addr_B !== 5'd0 || in_d !== 16'h0) begin n_fail++; $display("FAIL rst_bus got %h/%h/%h want 0", Addr_A, Addr_B, in_d); end
    n_vec++; if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_status got rdv=%b busy=%b want 0/0", bus.rd_valid, bus.busy); end
    n_vec++; if ({RegWrtBar, srclkneg, srclkpos} !== 3'b010) begin n_fail++; $display("FAIL clk_gen_ph6 got %b want 010", {RegWrtBar, srclkneg, srclkpos}); end
    guard = 0;
    do begin @(negedge clk); guard++; end while (!(ph == 3 && cnt == 1) && guard < 100);
    n_vec++; if ({RegWrtBar, srclkneg, srclkpos} !== 3'b101) begin n_fail++; $display("FAIL clk_gen_ph3 got %b want 101", {RegWrtBar, srclkneg, srclkpos}); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write();
    run_txn(1'b1, 5'd1, 5'd2, 16'hAAAA, 0);
    n_vec++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL wr_timeout got %b want 0", obs_timeout); end
    n_vec++; if (obs_ph_addr !== 2 || obs_n_addr !== 7) begin n_fail++; $display("FAIL wr_addr_edge got ph=%0d n=%0d want 2/7", obs_ph_addr, obs_n_addr); end
    n_vec++; if (obs_ph_in !== 4) begin n_fail++; $display("FAIL wr_data_phase got %0d want 4", obs_ph_in); end
    n_vec++; if (obs_we_on !== 8 || obs_we_off !== 9 || obs_we_cyc !== 3) begin n_fail++; $display("FAIL wr_enable got on=%0d off=%0d len=%0d want 8/9/3", obs_we_on, obs_we_off, obs_we_cyc); end
    n_vec++; if (obs_re_cyc !== 0 || obs_rdv !== 0) begin n_fail++; $display("FAIL wr_no_read got re=%0d rdv=%0d want 0/0", obs_re_cyc, obs_rdv); end
    n_vec++; if (obs_ready_early !== 1'b0) begin n_fail++; $display("FAIL wr_ready_early got %b want 0", obs_ready_early); end
  endtask

  task automatic test_read();
    outA = 16'hAAAA; outB = 16'h0000;
    run_txn(1'b0, 5'd1, 5'd0, 16'h1234, 0);
    n_vec++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL rd_timeout got %b want 0", obs_timeout); end
    n_vec++; if (obs_ph_addr !== 2) begin n_fail++; $display("FAIL rd_addr_phase got %0d want 2", obs_ph_addr); end
    n_vec++; if (obs_re_on !== 6 || obs_re_off !== 8 || obs_re_cyc !== 6) begin n_fail++; $display("FAIL rd_enable got on=%0d off=%0d len=%0d want 6/8/6", obs_re_on, obs_re_off, obs_re_cyc); end
    n_vec++; if (obs_we_cyc !== 0) begin n_fail++; $display("FAIL rd_no_write got %0d want 0", obs_we_cyc); end
    n_vec++; if (obs_rdv !== 1) begin n_fail++; $display("FAIL rd_valid_pulse got %0d want 1", obs_rdv); end
    n_vec++; if (obs_rd_a !== 16'hAAAA || obs_rd_b !== 16'h0000) begin n_fail++; $display("FAIL rd_data got %h/%h want aaaa/0000", obs_rd_a, obs_rd_b); end
    n_vec++; if (in_d !== 16'hAAAA) begin n_fail++; $display("FAIL rd_in_hold got %h want aaaa", in_d); end
  endtask

  task automatic test_late_request();
    outA = 16'h0101; outB = 16'h0202;
    run_txn(1'b0, 5'd5, 5'd6, 16'h0000, 3);
    n_vec++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL late_timeout got %b want 0", obs_timeout); end
    n_vec++; if (obs_ph_addr !== 2 || obs_n_addr !== 28) begin n_fail++; $display("FAIL late_addr got ph=%0d n=%0d want 2/28", obs_ph_addr, obs_n_addr); end
    n_vec++; if (obs_ready_early !== 1'b0) begin n_fail++; $display("FAIL late_ready_early got %b want 0", obs_ready_early); end
    n_vec++; if (obs_rd_a !== 16'h0101 || obs_rd_b !== 16'h0202) begin n_fail++; $display("FAIL late_data got %h/%h want 0101/0202", obs_rd_a, obs_rd_b); end
    run_txn(1'b0, 5'd7, 5'd8, 16'h0000, 2);
    n_vec++; if (obs_ph_addr !== 2 || obs_n_addr !== 31) begin n_fail++; $display("FAIL same_edge_addr got ph=%0d n=%0d want 2/31", obs_ph_addr, obs_n_addr); end
    n_vec++; if (obs_rdv !== 1 || obs_timeout !== 1'b0) begin n_fail++; $display("FAIL same_edge_done got rdv=%0d to=%b want 1/0", obs_rdv, obs_timeout); end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!(ph == 0 && cnt == 0 && bus.req_ready) && guard < 200);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1;
    bus.req_addr_a = 5'd9; bus.req_addr_b = 5'd10; bus.req_wdata = 16'h5555;
    @(negedge clk);
    bus.req_valid = 1'b0;
    guard = 0;
    while (WriteEn !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    n_vec++; if (WriteEn !== 1'b1) begin n_fail++; $display("FAIL mid_we_reach got %b want 1", WriteEn); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (WriteEn !== 1'b0 || ReadEn !== 1'b0) begin n_fail++; $display("FAIL mid_we_drop got we=%b re=%b want 0/0", WriteEn, ReadEn); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_status got rdy=%b busy=%b rdv=%b want 1/0/0", bus.req_ready, bus.busy, bus.rd_valid); end
    n_vec++; if (Addr_A !== 5'd0 || Addr_B !== 5'd0 || in_d !== 16'h0) begin n_fail++; $display("FAIL mid_bus got %h/%h/%h want 0", Addr_A, Addr_B, in_d); end
  endtask

  task automatic test_back_to_back();
    bit            t_wr [3] = '{1'b1, 1'b0, 1'b1};
    logic [AW-1:0] t_a  [3] = '{5'd11, 5'd13, 5'd15};
    logic [AW-1:0] t_b  [3] = '{5'd12, 5'd14, 5'd16};
    logic [DW-1:0] t_d  [3] = '{16'h1111, 16'h0000, 16'h2222};
    int en_cyc [3];
    int idx, ne, nwe, nre, guard;
    bit fin, both, garbage;
    logic pwe, pre;
    idx = 0; ne = 0; nwe = 0; nre = 0; fin = 0; both = 0; garbage = 0;
    en_cyc = '{-1, -1, -1};
    outA = 16'h0000; outB = 16'h0000;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!bus.req_ready && guard < 200);
    bus.req_valid = 1'b1;
    pwe = WriteEn; pre = ReadEn;
    for (int i = 0; i < 600 && !fin; i++) begin
      if (bus.req_ready) begin
        if (idx < 3) begin
          bus.req_wr = t_wr[idx]; bus.req_addr_a = t_a[idx];
          bus.req_addr_b = t_b[idx]; bus.req_wdata = t_d[idx];
          idx++;
        end else begin
          bus.req_valid = 1'b0; fin = 1;
        end
      end else begin
        bus.req_wr = 1'b1; bus.req_addr_a = 5'd31; bus.req_addr_b = 5'd31; bus.req_wdata = 16'hFFFF;
      end
      if (!fin) begin
        @(negedge clk);
        if (WriteEn && !pwe) begin nwe++; if (ne < 3) en_cyc[ne] = bcyc; ne++; end
        if (ReadEn && !pre) begin nre++; if (ne < 3) en_cyc[ne] = bcyc; ne++; end
        if (WriteEn && ReadEn) both = 1;
        if (Addr_A == 5'd31 || Addr_B == 5'd31) garbage = 1;
        pwe = WriteEn; pre = ReadEn;
      end
    end
    bus.req_valid = 1'b0;
    n_vec++; if (fin !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout got fin=%b want 1", fin); end
    n_vec++; if (nwe !== 2 || nre !== 1) begin n_fail++; $display("FAIL b2b_pulses got we=%0d re=%0d want 2/1", nwe, nre); end
    n_vec++; if (both !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap got %b want 0", both); end
    n_vec++; if (garbage !== 1'b0) begin n_fail++; $display("FAIL b2b_dropped got %b want 0", garbage); end
    n_vec++; if (en_cyc[1] !== en_cyc[0] + 1 || en_cyc[2] !== en_cyc[0] + 2) begin n_fail++; $display("FAIL b2b_cycles got %0d/%0d/%0d want consecutive", en_cyc[0], en_cyc[1], en_cyc[2]); end
    n_vec++; if (Addr_A !== 5'd15 || Addr_B !== 5'd16 || in_d !== 16'h2222) begin n_fail++; $display("FAIL b2b_final got %h/%h/%h want 0f/10/2222", Addr_A, Addr_B, in_d); end
  endtask

  task automatic test_forward();
    logic [DW-1:0] exp_d;
`ifdef WR_FORWARD_EN
    exp_d = 16'h1234;
`else
    exp_d = 16'h0000;
`endif
    outA = 16'h0000; outB = 16'h0000;
    run_txn(1'b1, 5'd3, 5'd4, 16'h1234, 0);
    n_vec++; if (obs_timeout !== 1'b0 || obs_we_cyc !== 3) begin n_fail++; $display("FAIL fwd_write got to=%b len=%0d want 0/3", obs_timeout, obs_we_cyc); end
    run_txn(1'b0, 5'd3, 5'd3, 16'h0000, 0);
    n_vec++; if (obs_rdv !== 1) begin n_fail++; $display("FAIL fwd_rdv got %0d want 1", obs_rdv); end
    n_vec++; if (obs_rd_a !== exp_d || obs_rd_b !== exp_d) begin n_fail++; $display("FAIL fwd_data got %h/%h want %h/%h", obs_rd_a, obs_rd_b, exp_d, exp_d); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_late_request();
    test_reset_mid();
    test_back_to_back();
    test_forward();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
